// File: rtl/upsample_2d.sv
// upsample_2d: expands a decimated raster stream back to full resolution by
// pixel replication. Each input word is repeated dec_factor times along x, and
// each input row is repeated dec_factor times along y. The first copy of a row
// comes straight from the input (FILL). The remaining copies are replayed from
// a line buffer (REPLAY).
module upsample_2d #(
  parameter int unsigned dec_factor = 2,
  parameter int unsigned out_width  = 240,
  parameter int unsigned out_height = 480,
  parameter int unsigned data_w     = 16,
  parameter int unsigned in_width   = out_width / dec_factor
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [data_w-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [data_w-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int unsigned NumRows = out_height / dec_factor;
  localparam int unsigned HW      = (dec_factor > 1) ? $clog2(dec_factor) : 1;
  localparam int unsigned XW      = (in_width > 1) ? $clog2(in_width) : 1;
  localparam int unsigned YW      = (NumRows > 1) ? $clog2(NumRows) : 1;

  localparam logic [HW-1:0] RepMax   = HW'(dec_factor - 1);
  localparam logic [XW-1:0] XMax     = XW'(in_width - 1);
  localparam logic [YW-1:0] YMax     = YW'(NumRows - 1);
  localparam bit            MultiRep = (dec_factor > 1);

  if (dec_factor == 0 || (out_width % dec_factor) != 0 ||
      (out_height % dec_factor) != 0) begin : g_param_check
    $error("upsample_2d: out_width/out_height must be divisible by dec_factor >= 1");
  end

  typedef enum logic [0:0] {StFill, StReplay} state_e;

  state_e            r_state;
  logic [HW-1:0]     r_hrep;
  logic [XW-1:0]     r_x;
  logic [HW-1:0]     r_vrep;
  logic [YW-1:0]     r_y;
  logic [data_w-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [XW-1:0]     r_rd_ptr;
  logic [data_w-1:0] r_rd_data;
  logic [data_w-1:0] r_mem [in_width];

  logic              w_xfer;
  logic              w_last_rep;
  logic              w_in_ready;
  logic              w_accept;
  state_e            w_state_n;
  logic [HW-1:0]     w_hrep_n;
  logic [XW-1:0]     w_x_n;
  logic [HW-1:0]     w_vrep_n;
  logic [YW-1:0]     w_y_n;
  logic              w_valid_n;
  logic [data_w-1:0] w_data_n;
  logic              w_last_n;
  logic              w_rd_en;
  logic [XW-1:0]     w_rd_addr;
  logic [XW-1:0]     w_rd_ptr_n;

  // Counters always describe the beat held in the output register, or the
  // next beat to present when that register is empty.
  assign w_xfer     = r_out_valid && out_ready;
  assign w_last_rep = (r_hrep == RepMax);

  // The output register doubles as the hold register in FILL. A new word may
  // enter while its predecessor's final replica leaves, except at the end of
  // a row that is followed by replay.
  assign w_in_ready = reset && (r_state == StFill) &&
                      (!r_out_valid ||
                       (out_ready && w_last_rep && !(MultiRep && (r_x == XMax))));
  assign w_accept   = in_valid && w_in_ready;

  // Next-state for counters, output register and line-buffer read-ahead.
  always_comb begin
    w_state_n  = r_state;
    w_hrep_n   = r_hrep;
    w_x_n      = r_x;
    w_vrep_n   = r_vrep;
    w_y_n      = r_y;
    w_valid_n  = r_out_valid;
    w_data_n   = r_out_data;
    w_rd_en    = 1'b0;
    w_rd_addr  = r_rd_ptr;
    w_rd_ptr_n = r_rd_ptr;

    if (w_xfer) begin
      if (w_last_rep) begin
        w_hrep_n  = '0;
        w_valid_n = 1'b0;  // word exhausted; reloaded below if one is ready
        if (r_x == XMax) begin
          w_x_n = '0;
          if (r_vrep == RepMax) begin
            w_vrep_n  = '0;
            w_y_n     = (r_y == YMax) ? '0 : r_y + YW'(1);
            w_state_n = StFill;
          end else begin
            // Another copy of this row follows: start fetching word 0 now.
            w_vrep_n   = r_vrep + HW'(1);
            w_state_n  = StReplay;
            w_rd_en    = 1'b1;
            w_rd_addr  = '0;
            w_rd_ptr_n = '0;
          end
        end else begin
          w_x_n = r_x + XW'(1);
        end
      end else begin
        w_hrep_n = r_hrep + HW'(1);
      end
    end

    if (r_state == StFill) begin
      if (w_accept) begin
        w_valid_n = 1'b1;
        w_data_n  = in_data;
      end
    end else if (!r_out_valid || (w_xfer && w_last_rep && !(r_x == XMax))) begin
      // Take the prefetched word and fetch the one after it.
      w_valid_n  = 1'b1;
      w_data_n   = r_rd_data;
      w_rd_en    = 1'b1;
      w_rd_addr  = (r_rd_ptr == XMax) ? '0 : r_rd_ptr + XW'(1);
      w_rd_ptr_n = w_rd_addr;
    end

    w_last_n = w_valid_n && (w_hrep_n == RepMax) && (w_x_n == XMax) &&
               (w_vrep_n == RepMax) && (w_y_n == YMax);
  end

  // FSM, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StFill;
      r_hrep      <= '0;
      r_x         <= '0;
      r_vrep      <= '0;
      r_y         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_rd_ptr    <= '0;
    end else begin
      r_state     <= w_state_n;
      r_hrep      <= w_hrep_n;
      r_x         <= w_x_n;
      r_vrep      <= w_vrep_n;
      r_y         <= w_y_n;
      r_out_data  <= w_data_n;
      r_out_valid <= w_valid_n;
      r_out_last  <= w_last_n;
      r_rd_ptr    <= w_rd_ptr_n;
    end
  end

  // Line buffer: written while filling a row, read with one cycle latency.
  always_ff @(posedge clk) begin
    if (w_accept && MultiRep) begin
      r_mem[w_x_n] <= in_data;
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule
